// File: rtl/reg_bus_arbiter_if.sv
// Bundle of the two requester ports and the register-map bus port of the
// register-bus arbiter. The "slave" modport is the arbiter's own view: it
// serves the two requesters and masters the register-map bus. The "master"
// modport is the view of everything surrounding the arbiter.
interface reg_bus_arbiter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   // requester port 0 (APB slave bridge)
   logic                  m0_req;
   logic                  m0_is_wr;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wr_data;
   logic [DATA_WIDTH-1:0] m0_wr_biten;
   logic                  m0_ready;
   logic                  m0_err;
   logic [DATA_WIDTH-1:0] m0_rd_data;
   // requester port 1 (auxiliary config/debug master)
   logic                  m1_req;
   logic                  m1_is_wr;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wr_data;
   logic [DATA_WIDTH-1:0] m1_wr_biten;
   logic                  m1_ready;
   logic                  m1_err;
   logic [DATA_WIDTH-1:0] m1_rd_data;
   // register-map bus
   logic                  bus_req;
   logic                  bus_req_is_wr;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [DATA_WIDTH-1:0] bus_wr_data;
   logic [DATA_WIDTH-1:0] bus_wr_biten;
   logic                  bus_req_stall_wr;
   logic                  bus_req_stall_rd;
   logic                  bus_ready;
   logic                  bus_err;
   logic [DATA_WIDTH-1:0] bus_rd_data;

   modport slave (
      input  m0_req, m0_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
      output m0_ready, m0_err, m0_rd_data,
      input  m1_req, m1_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
      output m1_ready, m1_err, m1_rd_data,
      output bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
      input  bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_err, bus_rd_data
   );

   modport master (
      output m0_req, m0_is_wr, m0_addr, m0_wr_data, m0_wr_biten,
      input  m0_ready, m0_err, m0_rd_data,
      output m1_req, m1_is_wr, m1_addr, m1_wr_data, m1_wr_biten,
      input  m1_ready, m1_err, m1_rd_data,
      input  bus_req, bus_req_is_wr, bus_addr, bus_wr_data, bus_wr_biten,
      output bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_err, bus_rd_data
   );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter and sequencer for the register-map bus.
// One transaction at a time: grant, issue a single-cycle bus_req (honouring
// the direction-specific stall), wait for the acknowledge or time out, then
// return a one-cycle ready pulse to the granted requester.
module reg_bus_arbiter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int TIMEOUT    = 16
) (
   input logic              clk,
   input logic              rst,
   reg_bus_arbiter_if.slave bus_if
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_e;

   state_e                state_q, state_d;
   logic                  last_q, last_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  gnt_port_q, gnt_port_d;
   logic                  gnt_is_wr_q, gnt_is_wr_d;
   logic [ADDR_WIDTH-1:0] gnt_addr_q, gnt_addr_d;
   logic [DATA_WIDTH-1:0] gnt_wr_data_q, gnt_wr_data_d;
   logic [DATA_WIDTH-1:0] gnt_wr_biten_q, gnt_wr_biten_d;
   logic                  m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
   logic                  m0_err_q, m0_err_d, m1_err_q, m1_err_d;
   logic [DATA_WIDTH-1:0] m0_rd_data_q, m0_rd_data_d, m1_rd_data_q, m1_rd_data_d;

   logic                  win_s;
   logic                  stall_s;
   logic                  resp_load_s;
   logic                  resp_err_s;
   logic [DATA_WIDTH-1:0] resp_data_s;

   // Round-robin winner: on a tie the port that did not go last wins
   always_comb begin
      win_s = 1'b0;
      if (bus_if.m0_req && bus_if.m1_req) begin
         win_s = ~last_q;
      end else if (bus_if.m1_req) begin
         win_s = 1'b1;
      end else begin
         win_s = 1'b0;
      end
   end

   // Next-state, grant capture, timeout counting and response capture
   always_comb begin
      state_d        = state_q;
      last_d         = last_q;
      cnt_d          = cnt_q;
      gnt_port_d     = gnt_port_q;
      gnt_is_wr_d    = gnt_is_wr_q;
      gnt_addr_d     = gnt_addr_q;
      gnt_wr_data_d  = gnt_wr_data_q;
      gnt_wr_biten_d = gnt_wr_biten_q;
      m0_ready_d     = 1'b0;
      m1_ready_d     = 1'b0;
      m0_err_d       = 1'b0;
      m1_err_d       = 1'b0;
      m0_rd_data_d   = {DATA_WIDTH{1'b0}};
      m1_rd_data_d   = {DATA_WIDTH{1'b0}};
      resp_load_s    = 1'b0;
      resp_err_s     = 1'b0;
      resp_data_s    = {DATA_WIDTH{1'b0}};
      stall_s        = gnt_is_wr_q ? bus_if.bus_req_stall_wr : bus_if.bus_req_stall_rd;
      case (state_q)
         ST_IDLE: begin
            if (bus_if.m0_req || bus_if.m1_req) begin
               last_d         = win_s;
               gnt_port_d     = win_s;
               gnt_is_wr_d    = win_s ? bus_if.m1_is_wr    : bus_if.m0_is_wr;
               gnt_addr_d     = win_s ? bus_if.m1_addr     : bus_if.m0_addr;
               gnt_wr_data_d  = win_s ? bus_if.m1_wr_data  : bus_if.m0_wr_data;
               gnt_wr_biten_d = win_s ? bus_if.m1_wr_biten : bus_if.m0_wr_biten;
               cnt_d          = {CNT_W{1'b0}};
               state_d        = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            if (stall_s) begin
               cnt_d = {CNT_W{1'b0}};
            end else if (bus_if.bus_ready) begin
               resp_load_s = 1'b1;
               resp_err_s  = bus_if.bus_err;
               resp_data_s = bus_if.bus_rd_data;
               state_d     = ST_RESP;
            end else begin
               cnt_d   = CNT_W'(1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // a real acknowledge beats a timeout landing in the same cycle
            if (bus_if.bus_ready) begin
               resp_load_s = 1'b1;
               resp_err_s  = bus_if.bus_err;
               resp_data_s = bus_if.bus_rd_data;
               state_d     = ST_RESP;
            end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
               resp_load_s = 1'b1;
               resp_err_s  = 1'b1;
               resp_data_s = {DATA_WIDTH{1'b0}};
               state_d     = ST_RESP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_RESP: begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      // steer the captured response to the granted port only
      if (resp_load_s && gnt_port_q) begin
         m1_ready_d   = 1'b1;
         m1_err_d     = resp_err_s;
         m1_rd_data_d = resp_data_s;
      end else if (resp_load_s) begin
         m0_ready_d   = 1'b1;
         m0_err_d     = resp_err_s;
         m0_rd_data_d = resp_data_s;
      end else begin
         m0_ready_d = 1'b0;
      end
   end

   // State, grant and response registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         last_q         <= 1'b1;
         cnt_q          <= {CNT_W{1'b0}};
         gnt_port_q     <= 1'b0;
         gnt_is_wr_q    <= 1'b0;
         gnt_addr_q     <= {ADDR_WIDTH{1'b0}};
         gnt_wr_data_q  <= {DATA_WIDTH{1'b0}};
         gnt_wr_biten_q <= {DATA_WIDTH{1'b0}};
         m0_ready_q     <= 1'b0;
         m1_ready_q     <= 1'b0;
         m0_err_q       <= 1'b0;
         m1_err_q       <= 1'b0;
         m0_rd_data_q   <= {DATA_WIDTH{1'b0}};
         m1_rd_data_q   <= {DATA_WIDTH{1'b0}};
      end else begin
         state_q        <= state_d;
         last_q         <= last_d;
         cnt_q          <= cnt_d;
         gnt_port_q     <= gnt_port_d;
         gnt_is_wr_q    <= gnt_is_wr_d;
         gnt_addr_q     <= gnt_addr_d;
         gnt_wr_data_q  <= gnt_wr_data_d;
         gnt_wr_biten_q <= gnt_wr_biten_d;
         m0_ready_q     <= m0_ready_d;
         m1_ready_q     <= m1_ready_d;
         m0_err_q       <= m0_err_d;
         m1_err_q       <= m1_err_d;
         m0_rd_data_q   <= m0_rd_data_d;
         m1_rd_data_q   <= m1_rd_data_d;
      end
   end

   // bus_req is the only combinational output: state and stall only
   assign bus_if.bus_req       = (state_q == ST_ISSUE) && !stall_s;
   assign bus_if.bus_req_is_wr = gnt_is_wr_q;
   assign bus_if.bus_addr      = gnt_addr_q;
   assign bus_if.bus_wr_data   = gnt_wr_data_q;
   assign bus_if.bus_wr_biten  = gnt_wr_biten_q;
   assign bus_if.m0_ready      = m0_ready_q;
   assign bus_if.m1_ready      = m1_ready_q;
   assign bus_if.m0_err        = m0_err_q;
   assign bus_if.m1_err        = m1_err_q;
   assign bus_if.m0_rd_data    = m0_rd_data_q;
   assign bus_if.m1_rd_data    = m1_rd_data_q;
endmodule
